id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe_pkg.sv | 16 +
 rtl/id_ex_pipe_if.sv | 46 ++++
 rtl/id_ex_pipe_load_use_detect.sv | 21 ++
 rtl/id_ex_pipe.sv | 94 +++++++++
 tb/tb_id_ex_pipe.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the ID/EX pipeline register slice: operand widths,
// register index width and the bit layout of the decoded control bundle.
package id_ex_pipe_pkg;

    localparam int RSIZE_DEF       = 32;
    localparam int REG_IDX_W       = 5;
    localparam int CWIDTH_DEF      = 8;

    localparam int CTRL_RWRITE     = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_ALU_OP_LSB = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute bus. The master side is the surrounding pipeline
// (decode drives the in_* fields, execute drives ex_ready, control drives
// flush); the slave side is the id_ex_pipe register slice.
interface id_ex_pipe_if
    import id_ex_pipe_pkg::*;
#(
    parameter int RSIZE  = RSIZE_DEF,
    parameter int CWIDTH = CWIDTH_DEF
);

    logic              in_valid;
    logic              in_ready;
    reg_idx_t          r1_idx;
    reg_idx_t          r2_idx;
    logic [RSIZE-1:0]  r1_data;
    logic [RSIZE-1:0]  r2_data;
    logic [RSIZE-1:0]  imm;
    reg_idx_t          wr_idx;
    logic [CWIDTH-1:0] ctrl;
    logic              flush;
    logic              ex_ready;

    logic              ex_valid;
    logic [RSIZE-1:0]  ex_r1;
    logic [RSIZE-1:0]  ex_r2;
    logic [RSIZE-1:0]  ex_imm;
    reg_idx_t          ex_r1_idx;
    reg_idx_t          ex_r2_idx;
    reg_idx_t          ex_wr_idx;
    logic [CWIDTH-1:0] ex_ctrl;

    modport master (
        output in_valid, r1_idx, r2_idx, r1_data, r2_data, imm, wr_idx, ctrl,
        output flush, ex_ready,
        input  in_ready, ex_valid, ex_r1, ex_r2, ex_imm,
        input  ex_r1_idx, ex_r2_idx, ex_wr_idx, ex_ctrl
    );

    modport slave (
        input  in_valid, r1_idx, r2_idx, r1_data, r2_data, imm, wr_idx, ctrl,
        input  flush, ex_ready,
        output in_ready, ex_valid, ex_r1, ex_r2, ex_imm,
        output ex_r1_idx, ex_r2_idx, ex_wr_idx, ex_ctrl
    );

endinterface

// File: rtl/id_ex_pipe_load_use_detect.sv
// Load-use hazard detector: flags when the decode instruction reads a
// register that the held load has not yet produced. x0 never hazards.
module load_use_detect
    import id_ex_pipe_pkg::*;
(
    input  logic     in_valid,
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_wr_idx,
    input  reg_idx_t r1_idx,
    input  reg_idx_t r2_idx,
    output logic     hazard
);

    // Pure combinational compare of the held load's destination against both sources
    always_comb begin
        hazard = in_valid && ex_valid && ex_mem_read && (ex_wr_idx != '0) &&
                 ((ex_wr_idx == r1_idx) || (ex_wr_idx == r2_idx));
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, load-use bubble
// insertion, flush, and a saturating count of load-use stall cycles.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int RSIZE  = RSIZE_DEF,
    parameter int CWIDTH = CWIDTH_DEF
)(
    input  logic        clk,
    input  logic        rst,
    id_ex_pipe_if.slave bus,
    output logic [15:0] stall_cnt
);

    logic              valid_q;
    logic [CWIDTH-1:0] ctrl_q;
    logic [RSIZE-1:0]  r1_q;
    logic [RSIZE-1:0]  r2_q;
    logic [RSIZE-1:0]  imm_q;
    reg_idx_t          r1_idx_q;
    reg_idx_t          r2_idx_q;
    reg_idx_t          wr_idx_q;
    logic [15:0]       stall_q;
    logic              hazard;
    logic              accept;

    load_use_detect u_detect (
        .in_valid    (bus.in_valid),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
        .ex_wr_idx   (wr_idx_q),
        .r1_idx      (bus.r1_idx),
        .r2_idx      (bus.r2_idx),
        .hazard      (hazard)
    );

    // Decode may advance only when the slot frees up this cycle, there is no
    // pending load-use dependency, and nothing is being flushed
    always_comb begin
        bus.in_ready = (!valid_q || bus.ex_ready) && !hazard && !bus.flush;
        accept       = bus.in_valid && bus.in_ready;
    end

    // Held slot: flush kills it, an accept replaces it, a consume empties it
    // (this also inserts the load-use bubble), otherwise execute is stalling
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            imm_q    <= '0;
            r1_idx_q <= '0;
            r2_idx_q <= '0;
            wr_idx_q <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            ctrl_q   <= bus.ctrl;
            r1_q     <= bus.r1_data;
            r2_q     <= bus.r2_data;
            imm_q    <= bus.imm;
            r1_idx_q <= bus.r1_idx;
            r2_idx_q <= bus.r2_idx;
            wr_idx_q <= bus.wr_idx;
        end else if (bus.ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Count every cycle the hazard holds decode back, unless a flush makes it moot
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (hazard && !bus.flush && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    // Control is masked when the slot is empty so execute never sees stale writes
    always_comb begin
        bus.ex_valid  = valid_q;
        bus.ex_ctrl   = valid_q ? ctrl_q : '0;
        bus.ex_r1     = r1_q;
        bus.ex_r2     = r2_q;
        bus.ex_imm    = imm_q;
        bus.ex_r1_idx = r1_idx_q;
        bus.ex_r2_idx = r2_idx_q;
        bus.ex_wr_idx = wr_idx_q;
        stall_cnt     = stall_q;
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed, table-driven bench for id_ex_pipe: each record drives one cycle
// of inputs, checks in_ready before the edge and the latched outputs after it.
module tb_id_ex_pipe;

    localparam logic [31:0] K   = 32'h0F0F0F0F;
    localparam logic [7:0]  ALU = 8'h09;
    localparam logic [7:0]  LD  = 8'h03;
    localparam logic [7:0]  ST  = 8'h14;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  r1i;
        logic [4:0]  r2i;
        logic [31:0] r1d;
        logic [4:0]  wr;
        logic [7:0]  ctrl;
        logic        fl;
        logic        er;
        logic        e_rdy;
        logic        e_valid;
        logic [7:0]  e_ctrl;
        logic        chk_data;
        logic [31:0] e_r1;
        logic [4:0]  e_wr;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] stall_cnt;
    int          tests;
    int          fails;
    vec_t        vecs[$];

    id_ex_pipe_if #(.RSIZE(32), .CWIDTH(8)) bus();

    id_ex_pipe #(.RSIZE(32), .CWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic iv, input logic [4:0] r1i,
                                input logic [4:0] r2i, input logic [31:0] d,
                                input logic [4:0] wr, input logic [7:0] c,
                                input logic fl, input logic er, input logic erdy,
                                input logic ev, input logic [7:0] ec, input logic cd,
                                input logic [31:0] er1, input logic [4:0] ewr,
                                input logic [15:0] ecnt);
        vec_t v;
        v.rst = r; v.iv = iv; v.r1i = r1i; v.r2i = r2i; v.r1d = d; v.wr = wr;
        v.ctrl = c; v.fl = fl; v.er = er; v.e_rdy = erdy; v.e_valid = ev;
        v.e_ctrl = ec; v.chk_data = cd; v.e_r1 = er1; v.e_wr = ewr; v.e_cnt = ecnt;
        vecs.push_back(v);
    endfunction

    // Operand 2 and immediate are derived from operand 1 so one column covers all three
    task automatic applyStimulus(input vec_t v);
        rst          = v.rst;
        bus.in_valid = v.iv;
        bus.r1_idx   = v.r1i;
        bus.r2_idx   = v.r2i;
        bus.r1_data  = v.r1d;
        bus.r2_data  = v.r1d ^ K;
        bus.imm      = v.r1d + 32'd1;
        bus.wr_idx   = v.wr;
        bus.ctrl     = v.ctrl;
        bus.flush    = v.fl;
        bus.ex_ready = v.er;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        tests = 0;
        fails = 0;
        idle = '{rst: 1'b1, iv: 1'b0, r1i: 5'd0, r2i: 5'd0, r1d: 32'd0, wr: 5'd0,
                 ctrl: 8'd0, fl: 1'b0, er: 1'b0, e_rdy: 1'b0, e_valid: 1'b0,
                 e_ctrl: 8'd0, chk_data: 1'b0, e_r1: 32'd0, e_wr: 5'd0, e_cnt: 16'd0};

        //   rst iv r1i r2i data          wr  ctrl fl er | rdy ev ectrl cd  e_r1          e_wr e_cnt
        add(1, 1, 1,  2,  32'h000000A1, 3,  ALU, 0, 1,   1,  0, 8'h0, 1, 32'h0,        0,  0);  // 0 reset beats accept
        add(0, 1, 1,  2,  32'h11110001, 3,  ALU, 0, 1,   1,  1, ALU,  1, 32'h11110001, 3,  0);  // 1 stream
        add(0, 1, 4,  5,  32'h11110002, 6,  ALU, 0, 1,   1,  1, ALU,  1, 32'h11110002, 6,  0);  // 2
        add(0, 1, 7,  8,  32'h11110003, 9,  ALU, 0, 1,   1,  1, ALU,  1, 32'h11110003, 9,  0);  // 3
        add(0, 0, 0,  0,  32'h0,        0,  0,   0, 1,   1,  0, 8'h0, 0, 32'h0,        0,  0);  // 4 drain
        add(0, 1, 1,  2,  32'h00000010, 5,  LD,  0, 1,   1,  1, LD,   1, 32'h00000010, 5,  0);  // 5 load x5
        add(0, 1, 6,  5,  32'h00000011, 7,  ALU, 0, 1,   0,  0, 8'h0, 0, 32'h0,        0,  1);  // 6 use via r2 -> bubble
        add(0, 1, 6,  5,  32'h00000011, 7,  ALU, 0, 1,   1,  1, ALU,  1, 32'h00000011, 7,  1);  // 7 retry accepted
        add(0, 0, 0,  0,  32'h0,        0,  0,   0, 1,   1,  0, 8'h0, 0, 32'h0,        0,  1);  // 8
        add(0, 1, 2,  3,  32'h00000020, 0,  LD,  0, 1,   1,  1, LD,   1, 32'h00000020, 0,  1);  // 9 load x0
        add(0, 1, 0,  4,  32'h00000021, 8,  ST,  0, 1,   1,  1, ST,   1, 32'h00000021, 8,  1);  // 10 no stall on x0
        add(0, 1, 1,  2,  32'hDEADBEEF, 10, ALU, 0, 1,   1,  1, ALU,  1, 32'hDEADBEEF, 10, 1);  // 11
        add(0, 1, 3,  4,  32'h00000030, 11, ALU, 0, 0,   0,  1, ALU,  1, 32'hDEADBEEF, 10, 1);  // 12 execute stall
        add(0, 1, 3,  4,  32'h00000030, 11, ALU, 0, 0,   0,  1, ALU,  1, 32'hDEADBEEF, 10, 1);  // 13
        add(0, 1, 3,  4,  32'h00000030, 11, ALU, 0, 0,   0,  1, ALU,  1, 32'hDEADBEEF, 10, 1);  // 14
        add(0, 1, 3,  4,  32'h00000030, 11, ALU, 0, 0,   0,  1, ALU,  1, 32'hDEADBEEF, 10, 1);  // 15
        add(0, 1, 3,  4,  32'h00000030, 11, ALU, 0, 1,   1,  1, ALU,  1, 32'h00000030, 11, 1);  // 16 resumes
        add(0, 1, 5,  6,  32'h00000040, 12, ALU, 1, 1,   0,  0, 8'h0, 0, 32'h0,        0,  1);  // 17 flush blocks accept
        add(0, 1, 5,  6,  32'h00000041, 13, LD,  0, 1,   1,  1, LD,   1, 32'h00000041, 13, 1);  // 18
        add(0, 0, 0,  0,  32'h0,        0,  0,   1, 0,   0,  0, 8'h0, 0, 32'h0,        0,  1);  // 19 flush while stalled
        add(0, 1, 1,  2,  32'h00000050, 14, LD,  0, 1,   1,  1, LD,   1, 32'h00000050, 14, 1);  // 20
        add(0, 1, 14, 1,  32'h00000051, 15, ALU, 1, 1,   0,  0, 8'h0, 0, 32'h0,        0,  1);  // 21 flush over hazard, no count
        add(0, 1, 1,  2,  32'h00000052, 14, LD,  0, 1,   1,  1, LD,   1, 32'h00000052, 14, 1);  // 22
        add(0, 1, 14, 1,  32'h00000053, 15, ALU, 0, 0,   0,  1, LD,   1, 32'h00000052, 14, 2);  // 23 hazard + exec stall
        add(0, 1, 14, 1,  32'h00000053, 15, ALU, 0, 1,   0,  0, 8'h0, 0, 32'h0,        0,  3);  // 24 bubble
        add(0, 1, 14, 1,  32'h00000053, 15, ALU, 0, 1,   1,  1, ALU,  1, 32'h00000053, 15, 3);  // 25
        add(0, 1, 1,  2,  32'h00000060, 9,  LD,  0, 1,   1,  1, LD,   1, 32'h00000060, 9,  3);  // 26
        add(1, 1, 9,  3,  32'h00000061, 2,  ALU, 0, 1,   0,  0, 8'h0, 1, 32'h0,        0,  0);  // 27 reset mid-hazard
        add(0, 1, 9,  3,  32'h00000061, 2,  ALU, 0, 1,   1,  1, ALU,  1, 32'h00000061, 2,  0);  // 28 ready after reset

        applyStimulus(idle);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            logic [31:0] exp_r2;
            logic [31:0] exp_imm;
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].e_valid});
            checkOutput($sformatf("v%0d ex_ctrl", i), {24'd0, bus.ex_ctrl}, {24'd0, vecs[i].e_ctrl});
            checkOutput($sformatf("v%0d stall_cnt", i), {16'd0, stall_cnt}, {16'd0, vecs[i].e_cnt});
            if (vecs[i].chk_data) begin
                exp_r2  = (vecs[i].e_r1 == 32'd0) ? 32'd0 : (vecs[i].e_r1 ^ K);
                exp_imm = (vecs[i].e_r1 == 32'd0) ? 32'd0 : (vecs[i].e_r1 + 32'd1);
                checkOutput($sformatf("v%0d ex_r1", i), bus.ex_r1, vecs[i].e_r1);
                checkOutput($sformatf("v%0d ex_r2", i), bus.ex_r2, exp_r2);
                checkOutput($sformatf("v%0d ex_imm", i), bus.ex_imm, exp_imm);
                checkOutput($sformatf("v%0d ex_wr_idx", i), {27'd0, bus.ex_wr_idx}, {27'd0, vecs[i].e_wr});
            end
            if (i == 27) begin
                checkOutput("reset ex_r1_idx", {27'd0, bus.ex_r1_idx}, 32'd0);
                checkOutput("reset ex_r2_idx", {27'd0, bus.ex_r2_idx}, 32'd0);
            end
            if (i == 28) begin
                checkOutput("accept ex_r1_idx", {27'd0, bus.ex_r1_idx}, 32'd9);
                checkOutput("accept ex_r2_idx", {27'd0, bus.ex_r2_idx}, 32'd3);
            end
        end

        // Saturation: a load held by a stalled execute, with a dependent
        // instruction waiting, hazards every cycle
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.r1_idx   = 5'd1;
        bus.r2_idx   = 5'd2;
        bus.r1_data  = 32'h00000070;
        bus.r2_data  = 32'h00000071;
        bus.imm      = 32'h00000072;
        bus.wr_idx   = 5'd20;
        bus.ctrl     = LD;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sat load ctrl", {24'd0, bus.ex_ctrl}, {24'd0, LD});
        @(negedge clk);
        bus.r1_idx   = 5'd20;
        bus.r1_data  = 32'h00000080;
        bus.wr_idx   = 5'd21;
        bus.ctrl     = ALU;
        bus.ex_ready = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        checkOutput("sat cnt FFFE", {16'd0, stall_cnt}, 32'h0000FFFE);
        @(posedge clk);
        #1;
        checkOutput("sat cnt FFFF", {16'd0, stall_cnt}, 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat cnt held", {16'd0, stall_cnt}, 32'h0000FFFF);
        checkOutput("sat in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("sat ex_r1 held", bus.ex_r1, 32'h00000070);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
